// File: rtl/sync_ctrl_pkg.sv
// Shared definitions for the frame-synchronisation controller.
// Holds the state encoding, the datapath width and the metric latency
// used to derive the default warm-up length.
package sync_ctrl_pkg;

    // Sample and metric width, fixed by the delay-and-correlate datapath.
    localparam int DATA_W     = 32;
    // Pipeline latency of the metric datapath, in clocks.
    localparam int METRIC_LAT = 4;
    // Depth of the correlator delay line that must fill before the metric is valid.
    localparam int DELAY_LEN  = 32;
    // Default number of contiguous samples before the metric can be trusted.
    localparam int WARM_LEN_DEF = DELAY_LEN + METRIC_LAT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SEARCH = 2'd2,
        ST_PASS   = 2'd3
    } state_t;

    // Counter width able to hold the value 'limit' with one spare bit.
    function automatic int cnt_w(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/run_counter.sv
// Saturating consecutive-event counter.
// 'reached' reports that the count, including this cycle's hit, equals
// LIMIT, so the caller can act on the same cycle as the final event.
// 'reached' does not depend on 'clr', so the caller may fold it into 'clr'.
module run_counter
    import sync_ctrl_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hit,
    output logic reached
);

    localparam int CW = cnt_w(LIMIT);

    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    // Next count if this cycle's hit is taken, saturating at LIMIT.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        count_inc = count;
        if (hit && (count != CW'(LIMIT)))
            count_inc = count + 1'b1;
    end

    assign reached = (count_inc == CW'(LIMIT));

    // Count register: clear has priority over the increment.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else
            count <= count_inc;
    end

endmodule

// File: rtl/sync_ctrl.sv
// Frame-synchronisation controller around the delay-and-correlate metric.
// Warms up the metric pipeline, qualifies the metric against a captured
// threshold, then forwards one fixed-length frame on an AXI-Stream master.
// Optional macro SYNC_CTRL_TIMEOUT_EN adds a SEARCH timeout and 'timeout' port.
module sync_ctrl
    import sync_ctrl_pkg::*;
#(
    parameter int WARM_LEN  = WARM_LEN_DEF,
    parameter int HOLD_LEN  = 8,
    parameter int FRAME_LEN = 1280
`ifdef SYNC_CTRL_TIMEOUT_EN
    ,
    parameter int TMO_LEN   = 65535
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] thresh,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] met_in,
    input  logic [DATA_W-1:0] met_out,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              frame_start,
    output logic [1:0]        state_o
`ifdef SYNC_CTRL_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam int FCW = cnt_w(FRAME_LEN);

    state_t            state;
    logic [DATA_W-1:0] thr_q;
    logic [FCW-1:0]    frame_cnt;

    logic warm_hit, warm_clr, warm_done;
    logic hold_hit, hold_clr, hold_done;
    logic m_hs, frame_end;

`ifdef SYNC_CTRL_TIMEOUT_EN
    localparam int TCW = cnt_w(TMO_LEN);
    logic [TCW-1:0] tmo_cnt;
    logic           tmo_lock;
`endif

    // Any bubble or miss breaks the run; en low or a completed run also clears it.
    assign warm_hit  = (state == ST_WARMUP) && s_axis_tvalid;
    assign warm_clr  = !warm_hit || !en || warm_done;
    assign hold_hit  = (state == ST_SEARCH) && s_axis_tvalid && (met_out >= thr_q);
    assign hold_clr  = !hold_hit || !en || hold_done;

    assign m_hs      = (state == ST_PASS) && s_axis_tvalid && m_axis_tready;
    assign frame_end = m_hs && (frame_cnt == FCW'(FRAME_LEN - 1));
    assign state_o   = state;

    run_counter #(.LIMIT(WARM_LEN)) u_warm (
        .clk     (clk),
        .rst     (rst),
        .clr     (warm_clr),
        .hit     (warm_hit),
        .reached (warm_done)
    );

    run_counter #(.LIMIT(HOLD_LEN)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .clr     (hold_clr),
        .hit     (hold_hit),
        .reached (hold_done)
    );

    // Stream steering: feed the metric while searching, pass through in PASS.
    always_comb begin
        s_axis_tready = 1'b0;
        met_in        = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state)
            ST_WARMUP, ST_SEARCH: begin
                s_axis_tready = 1'b1;
                met_in        = s_axis_tvalid ? s_axis_tdata : '0;
            end
            ST_PASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = (frame_cnt == FCW'(FRAME_LEN - 1));
            end
            default: ;
        endcase
    end

    // Control FSM with registered threshold, frame counter and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            thr_q       <= '0;
            frame_cnt   <= '0;
            frame_start <= 1'b0;
`ifdef SYNC_CTRL_TIMEOUT_EN
            tmo_cnt     <= '0;
            tmo_lock    <= 1'b0;
            timeout     <= 1'b0;
`endif
        end else begin
            frame_start <= 1'b0;
`ifdef SYNC_CTRL_TIMEOUT_EN
            timeout     <= 1'b0;
            if (!en)
                tmo_lock <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
`ifdef SYNC_CTRL_TIMEOUT_EN
                    if (en && !tmo_lock) begin
`else
                    if (en) begin
`endif
                        thr_q <= thresh;
                        state <= ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (warm_done) begin
                        state <= ST_SEARCH;
`ifdef SYNC_CTRL_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                ST_SEARCH: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (!s_axis_tvalid) begin
                        state <= ST_WARMUP;
                    end else if (hold_done) begin
                        state       <= ST_PASS;
                        frame_start <= 1'b1;
                    end
`ifdef SYNC_CTRL_TIMEOUT_EN
                    else if (tmo_cnt == TCW'(TMO_LEN - 1)) begin
                        state    <= ST_IDLE;
                        timeout  <= 1'b1;
                        tmo_lock <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_PASS: begin
                    if (frame_end) begin
                        frame_cnt <= '0;
                        state     <= en ? ST_WARMUP : ST_IDLE;
                    end else if (m_hs) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_ctrl.sv
// Self-checking bench for sync_ctrl with small lengths so every corner is reachable.
module tb_sync_ctrl;
    import sync_ctrl_pkg::*;

    localparam int W_LEN = 4;
    localparam int H_LEN = 3;
    localparam int F_LEN = 5;
    localparam int T_LEN = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              m_axis_tready = 1'b0;
    logic [DATA_W-1:0] thresh = '0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic [DATA_W-1:0] met_out = '0;
    logic              s_axis_tready, m_axis_tvalid, m_axis_tlast, frame_start;
    logic [DATA_W-1:0] met_in, m_axis_tdata;
    logic [1:0]        state_o;
`ifdef SYNC_CTRL_TIMEOUT_EN
    logic              timeout;
`endif

    sync_ctrl #(
        .WARM_LEN  (W_LEN),
        .HOLD_LEN  (H_LEN),
        .FRAME_LEN (F_LEN)
`ifdef SYNC_CTRL_TIMEOUT_EN
        ,
        .TMO_LEN   (T_LEN)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .thresh        (thresh),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .met_in        (met_in),
        .met_out       (met_out),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_start   (frame_start),
        .state_o       (state_o)
`ifdef SYNC_CTRL_TIMEOUT_EN
        ,
        .timeout       (timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 warming, 2 searching, 3 forwarding.
    int          md, run, hits, sent, tmo;
    logic [31:0] m_thr;
    bit          m_fs, m_tp, m_lock;

    logic [31:0] thr_drive = 32'd100;
    bit          last_sready, last_tlast;
    logic [31:0] got_q[$];
    bit          last_q[$];

    typedef struct {
        bit          en, tv, mr;
        logic [31:0] d, met;
        int          st;
        bit          fs, srdy, mval, tlast;
        logic [31:0] mdata;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        md = 0; run = 0; hits = 0; sent = 0; tmo = 0;
        m_thr = '0; m_fs = 0; m_tp = 0; m_lock = 0;
    endtask

    task automatic model_edge();
        bit lock_old;
        lock_old = m_lock;
        m_fs = 0;
        m_tp = 0;
        if (!en) m_lock = 0;
        case (md)
            0: if (en && !lock_old) begin m_thr = thresh; md = 1; run = 0; end
            1: begin
                if (!en) md = 0;
                else if (!s_axis_tvalid) run = 0;
                else begin
                    run++;
                    if (run == W_LEN) begin md = 2; run = 0; hits = 0; tmo = 0; end
                end
            end
            2: begin
                if (!en) md = 0;
                else if (!s_axis_tvalid) begin md = 1; run = 0; end
                else begin
                    hits = (met_out >= m_thr) ? hits + 1 : 0;
                    if (hits == H_LEN) begin md = 3; m_fs = 1; sent = 0; end
                    else begin
                        tmo++;
`ifdef SYNC_CTRL_TIMEOUT_EN
                        if (tmo == T_LEN) begin md = 0; m_tp = 1; m_lock = 1; end
`endif
                    end
                end
            end
            default: begin
                if (s_axis_tvalid && m_axis_tready) begin
                    sent++;
                    if (sent == F_LEN) begin sent = 0; md = en ? 1 : 0; run = 0; end
                end
            end
        endcase
    endtask

    task automatic check_model();
        check("state_o", state_o, md);
        check("frame_start", frame_start, m_fs);
        check("s_axis_tready", s_axis_tready, md == 0 ? 0 : (md == 3 ? m_axis_tready : 1));
        check("m_axis_tvalid", m_axis_tvalid, md == 3 ? s_axis_tvalid : 0);
        check("m_axis_tdata", m_axis_tdata, md == 3 ? s_axis_tdata : 0);
        check("m_axis_tlast", m_axis_tlast, (md == 3 && sent == F_LEN - 1));
        check("met_in", met_in, ((md == 1 || md == 2) && s_axis_tvalid) ? s_axis_tdata : 0);
`ifdef SYNC_CTRL_TIMEOUT_EN
        check("timeout", timeout, m_tp);
`endif
    endtask

    // One clock: drive at negedge, compare against the model, advance at posedge.
    task automatic step(input bit e, input bit v, input logic [31:0] d,
                        input logic [31:0] m, input bit r);
        @(negedge clk);
        en = e; s_axis_tvalid = v; s_axis_tdata = d; met_out = m; m_axis_tready = r;
        thresh = thr_drive;
        #1;
        check_model();
        last_sready = s_axis_tready;
        last_tlast  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back(m_axis_tdata);
            last_q.push_back(m_axis_tlast);
        end
        @(posedge clk);
        model_edge();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " state_o"}, state_o, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " s_axis_tready"}, s_axis_tready, 0);
        check({tag, " m_axis_tvalid"}, m_axis_tvalid, 0);
        check({tag, " m_axis_tlast"}, m_axis_tlast, 0);
        check({tag, " m_axis_tdata"}, m_axis_tdata, 0);
        check({tag, " met_in"}, met_in, 0);
    endtask

    initial begin
        //             en tv mr  d      met   st fs srdy mval tlast mdata
        vecs[0]  = '{1, 1, 1, 32'h01, 0,   0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 32'h02, 0,   1, 0, 1, 0, 0, 0};
        vecs[2]  = '{1, 1, 1, 32'h03, 0,   1, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 1, 1, 32'h04, 0,   1, 0, 1, 0, 0, 0};
        vecs[4]  = '{1, 1, 1, 32'h05, 0,   1, 0, 1, 0, 0, 0};
        vecs[5]  = '{1, 1, 1, 32'h06, 150, 2, 0, 1, 0, 0, 0};
        vecs[6]  = '{1, 1, 1, 32'h07, 150, 2, 0, 1, 0, 0, 0};
        vecs[7]  = '{1, 1, 1, 32'h08, 150, 2, 0, 1, 0, 0, 0};
        vecs[8]  = '{1, 1, 1, 32'h10, 0,   3, 1, 1, 1, 0, 32'h10};
        vecs[9]  = '{1, 1, 1, 32'h11, 0,   3, 0, 1, 1, 0, 32'h11};
        vecs[10] = '{1, 1, 1, 32'h12, 0,   3, 0, 1, 1, 0, 32'h12};
        vecs[11] = '{1, 1, 1, 32'h13, 0,   3, 0, 1, 1, 0, 32'h13};
        vecs[12] = '{1, 1, 1, 32'h14, 0,   3, 0, 1, 1, 1, 32'h14};
        vecs[13] = '{1, 1, 1, 32'h15, 0,   1, 0, 1, 0, 0, 0};

        // Reset state, with busy inputs so zero outputs mean something.
        thresh = 32'd100; en = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'hAA;
        m_axis_tready = 1'b1;
        #12;
        check_all_zero("reset");
        en = 1'b0; s_axis_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Warm-up, detection and one full frame from the vector table.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            en = vecs[i].en; s_axis_tvalid = vecs[i].tv; s_axis_tdata = vecs[i].d;
            met_out = vecs[i].met; m_axis_tready = vecs[i].mr; thresh = thr_drive;
            #1;
            check($sformatf("vec%0d state_o", i), state_o, vecs[i].st);
            check($sformatf("vec%0d frame_start", i), frame_start, vecs[i].fs);
            check($sformatf("vec%0d s_axis_tready", i), s_axis_tready, vecs[i].srdy);
            check($sformatf("vec%0d m_axis_tvalid", i), m_axis_tvalid, vecs[i].mval);
            check($sformatf("vec%0d m_axis_tlast", i), m_axis_tlast, vecs[i].tlast);
            check($sformatf("vec%0d m_axis_tdata", i), m_axis_tdata, vecs[i].mdata);
            @(posedge clk);
            model_edge();
        end

        // A miss in the run restarts the hold count: detection only after the 6th metric.
        for (int i = 0; i < 3; i++) step(1, 1, 32'h100 + i, 0, 1);
        #2 check("search_entry state_o", state_o, 2);
        begin
            logic [31:0] mets[6];
            mets = '{150, 150, 50, 150, 150, 150};
            for (int i = 0; i < 5; i++) begin
                step(1, 1, 32'h200 + i, mets[i], 1);
                #2 check($sformatf("no_early_detect%0d state_o", i), state_o, 2);
            end
            step(1, 1, 32'h205, mets[5], 1);
        end
        #2 check("late_detect state_o", state_o, 3);
        check("late_detect frame_start", frame_start, 1);
        for (int i = 0; i < F_LEN; i++) step(1, 1, 32'h20 + i, 0, 1);
        #2 check("frame_done state_o", state_o, 1);

        // Bubble after two hits drops back to WARMUP and needs a full warm-up again.
        for (int i = 0; i < W_LEN; i++) step(1, 1, 32'h300 + i, 0, 1);
        step(1, 1, 32'h310, 150, 1);
        step(1, 1, 32'h311, 150, 1);
        step(1, 0, 32'h312, 150, 1);
        #2 check("bubble state_o", state_o, 1);
        for (int i = 0; i < W_LEN - 1; i++) step(1, 1, 32'h320 + i, 150, 1);
        #2 check("rewarm_short state_o", state_o, 1);
        step(1, 1, 32'h323, 150, 1);
        #2 check("rewarm_done state_o", state_o, 2);
        for (int i = 0; i < H_LEN; i++) step(1, 1, 32'h330 + i, 150, 1);
        #2 check("bubble_detect state_o", state_o, 3);

        // Backpressure mid-frame, en dropped before the frame ends.
        got_q.delete(); last_q.delete();
        step(1, 1, 32'h30, 0, 1);
        step(1, 1, 32'h31, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h32, 0, 0);
            check($sformatf("stall%0d s_axis_tready", i), last_sready, 0);
        end
        step(1, 1, 32'h32, 0, 1);
        step(0, 1, 32'h33, 0, 1);
        step(0, 1, 32'h34, 0, 1);
        check("stall_frame tlast_on_5th", last_tlast, 1);
        #2 check("en_low_after_frame state_o", state_o, 0);
        check("stall_frame beats", got_q.size(), F_LEN);
        for (int i = 0; i < got_q.size() && i < F_LEN; i++) begin
            check($sformatf("stall_frame data%0d", i), got_q[i], 32'h30 + i);
            check($sformatf("stall_frame last%0d", i), last_q[i], (i == F_LEN - 1));
        end

        // Asynchronous reset in the middle of a frame.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < W_LEN; i++) step(1, 1, 32'h400 + i, 0, 1);
        for (int i = 0; i < H_LEN; i++) step(1, 1, 32'h410 + i, 200, 1);
        step(1, 1, 32'h40, 0, 1);
        step(1, 1, 32'h41, 0, 1);
        #3;
        en = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'h55; m_axis_tready = 1'b1;
        #1 check("pre_reset state_o", state_o, 3);
        rst = 1'b1;
        #1 check_all_zero("async_reset");
        en = 1'b0; s_axis_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

`ifdef SYNC_CTRL_TIMEOUT_EN
        // Timeout after T_LEN SEARCH cycles; re-arm needs en low for a cycle.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < W_LEN; i++) step(1, 1, i, 0, 1);
        for (int i = 0; i < T_LEN; i++) step(1, 1, i, 0, 1);
        #2 check("tmo timeout", timeout, 1);
        check("tmo state_o", state_o, 0);
        step(1, 1, 0, 0, 1);
        #2 check("tmo_locked state_o", state_o, 0);
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        #2 check("tmo_rearm state_o", state_o, 1);
`endif

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) thr_drive = $urandom_range(0, 255);
            step(($urandom % 100) < 97, ($urandom % 100) < 90, $urandom,
                 $urandom_range(0, 255), ($urandom % 100) < 80);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_ctrl.md
Name: sync_ctrl

Overview:
- Frame-synchronisation controller wrapped around the delay-and-correlate metric pipeline in the receiver front end.
- Accepts the ADC sample stream and feeds the metric datapath, which has no enable and shifts every clock.
- Qualifies the returned metric against a threshold, then declares frame start and forwards one fixed-length frame downstream on an AXI-Stream master.
- Re-arms automatically after each frame.

Parameters:
- DATA_W, 32, sample and metric width; fixed by the metric datapath.
- WARM_LEN, 36, contiguous accepted samples before the metric is trusted; covers delay-line fill plus 4-cycle metric latency.
- HOLD_LEN, 8, consecutive cycles with metric >= thresh required to declare a detection.
- FRAME_LEN, 1280, samples forwarded per detected frame.
- TMO_LEN, 65535, SEARCH cycles before timeout (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  level enable for the controller
- thresh  in  DATA_W  unsigned detection threshold; captured on IDLE->WARMUP
- s_axis_tdata  in  DATA_W  input sample
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- met_in  out  DATA_W  sample drive to the metric datapath
- met_out  in  DATA_W  metric returned from the datapath
- m_axis_tdata  out  DATA_W  forwarded sample
- m_axis_tvalid  out  1  forwarded valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last sample of frame
- frame_start  out  1  one-cycle detection pulse
- state_o  out  2  current state encoding, for debug and status

Behaviour:
- Reset, asynchronous: state IDLE; all counters 0; captured threshold 0; frame_start 0. Combinational outputs in IDLE: s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, met_in 0.
- State encoding: IDLE=0, WARMUP=1, SEARCH=2, PASS=3.
- IDLE: s_axis_tready=0. When en=1, capture thresh and go to WARMUP next cycle.
- WARMUP and SEARCH:
  - s_axis_tready=1 unconditionally.
  - met_in = s_axis_tdata when s_axis_tvalid=1, else 0.
  - m_axis_tvalid=0.
- Bubble rule: s_axis_tvalid=0 in WARMUP or SEARCH clears warm_cnt and hold_cnt and forces WARMUP, because metric contiguity is lost.
- WARMUP: warm_cnt increments per accepted sample. On the accept that makes warm_cnt == WARM_LEN, go to SEARCH.
- SEARCH:
  - Each cycle with s_axis_tvalid=1, hold_cnt increments if met_out >= captured threshold (unsigned); otherwise hold_cnt clears.
  - When hold_cnt reaches HOLD_LEN, go to PASS. frame_start is registered and is high for exactly the first cycle in PASS.
  - The metric is accepted as-is; no latency realignment is applied.
- PASS:
  - Combinational pass-through: m_axis_tdata = s_axis_tdata, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready.
  - met_in = 0. hold_cnt and warm_cnt are held at 0.
  - frame_cnt increments per m_axis handshake. m_axis_tlast = 1 when frame_cnt == FRAME_LEN-1.
  - After the last handshake, go to WARMUP if en=1, else IDLE. Backpressure stalls with no loss.
- en deasserted:
  - In WARMUP or SEARCH, go to IDLE next cycle.
  - In PASS, the current frame completes first.
- Simultaneous events: a bubble in the same cycle the detection threshold would be reached means the bubble wins and no detection occurs. en=0 beats any WARMUP->SEARCH transition.
- Counter widths: clog2 of each limit, plus 1 bit. No wrap is possible; each counter clears on its state exit.

Optional Feature:
- Macro SYNC_CTRL_TIMEOUT_EN.
- Defined:
  - Adds output port timeout (1 bit, registered, reset 0).
  - A tmo_cnt counts SEARCH cycles and clears on entry to SEARCH.
  - When tmo_cnt reaches TMO_LEN with no detection: pulse timeout for 1 cycle and go to IDLE.
  - Re-arm requires en to be low for 1 cycle, then high again.
- Undefined: no port and no counter; SEARCH waits indefinitely.

Decomposition:
- Package sync_ctrl_pkg holds:
  - state encodings ST_IDLE, ST_WARMUP, ST_SEARCH, ST_PASS;
  - the DATA_W constant;
  - the METRIC_LAT=4 constant, used to derive the WARM_LEN default.
- One sub-module run_counter:
  - function: saturating consecutive-event counter;
  - inputs: clk, rst, clr, hit;
  - output: reached (count == LIMIT);
  - instantiated for hold_cnt and warm_cnt.

Test Plan:
1. Setup for all scenarios: WARM_LEN=4, HOLD_LEN=3, FRAME_LEN=5, thresh=100.
2. Assert en with contiguous valid samples and met_out=0 -> state_o goes 0->1->2 after 4 accepts; frame_start stays 0; s_axis_tready=1.
3. In SEARCH, drive met_out = 150,150,150 -> state_o=3 on the next cycle, frame_start high for exactly 1 cycle. Then 5 samples 0x10..0x14 forward, with tlast on 0x14, and the block returns to WARMUP.
4. In SEARCH, drive met_out = 150,150,50,150,150,150 -> exactly one detection, after the 6th cycle. Repeat with a tvalid=0 bubble inserted after two hits -> block returns to WARMUP and needs 4 more accepts before detection is possible.
5. In PASS, hold m_axis_tready=0 for 3 cycles mid-frame -> s_axis_tready=0 during the stall, no sample is lost or duplicated, and tlast still lands on the 5th sample. Deassert en during PASS -> the frame completes, then IDLE.
6. Assert rst asynchronously mid-PASS -> all outputs are 0 immediately and state_o=0. With SYNC_CTRL_TIMEOUT_EN and TMO_LEN=10, holding met_out=0 gives a timeout pulse after 10 SEARCH cycles, then IDLE.
